// File: rtl/util_bfp_normalizer_pkg.sv
// Shared constants and state encoding for the block-floating-point normalizer.
package util_bfp_normalizer_pkg;

  // Block exponent range as seen by util_scaler.
  localparam int EXP_MIN        = -21;
  localparam int EXP_MAX        = 4;
  localparam int EXP_ZERO_SHIFT = 4;

  // The shift applied to samples is the negated exponent.
  localparam int K_MIN = -EXP_MAX;
  localparam int K_MAX = -EXP_MIN;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CALC    = 2'd2,
    ST_EMIT    = 2'd3
  } state_e;

  // Limit the raw shift to what the exponent field can express.
  function automatic int clamp_shift(input int k);
    if (k < K_MIN) return K_MIN;
    if (k > K_MAX) return K_MAX;
    return k;
  endfunction

endpackage

// File: rtl/util_bfp_normalizer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Contents are intentionally not reset.
module util_bfp_ram #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // Write port plus one-cycle registered read.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/util_bfp_normalizer.sv
// Buffers one complex frame, finds its common headroom, and replays it as
// shifted mantissas with a single shared block exponent.
module util_bfp_normalizer
  import util_bfp_normalizer_pkg::*;
#(
  parameter int INPUT_WIDTH  = 24,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    din_sop,
  input  logic                    din_eop,
  input  logic [INPUT_WIDTH-1:0]  din_real,
  input  logic [INPUT_WIDTH-1:0]  din_imag,
  input  logic [1:0]              din_error,
  input  logic                    dout_ready,
  output logic                    dout_valid,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic [OUTPUT_WIDTH-1:0] dout_real,
  output logic [OUTPUT_WIDTH-1:0] dout_imag,
  output logic [5:0]              dout_exp,
  output logic [1:0]              dout_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int HW    = $clog2(INPUT_WIDTH);
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int DW    = 2 * INPUT_WIDTH;

  // Number of bits directly below the MSB that repeat the MSB.
  function automatic logic [HW-1:0] lsb_count(input logic [INPUT_WIDTH-1:0] x);
    logic [HW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = INPUT_WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[INPUT_WIDTH-1])) n = n + HW'(1);
      else run = 1'b0;
    end
    return n;
  endfunction

  // Arithmetic right shift (floor) for k>0, left shift otherwise.
  function automatic logic [OUTPUT_WIDTH-1:0] scale(input logic [INPUT_WIDTH-1:0] x,
                                                    input logic signed [5:0] k);
    logic signed [INPUT_WIDTH-1:0] xs;
    logic        [INPUT_WIDTH-1:0] y;
    xs = signed'(x);
    if (k > 0) y = xs >>> k;
    else       y = x << (-k);
    return y[OUTPUT_WIDTH-1:0];
  endfunction

  state_e                state_q, state_d;
  logic                  din_ready_q;
  logic [LW-1:0]         len_q, len_d;
  logic [HW-1:0]         h_q, h_d;
  logic [1:0]            err_q, err_d;
  logic                  ovf_q, ovf_d;
  logic signed [5:0]     k_q, k_d;
  logic [LW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  infl_q, infl_sop_q, infl_eop_q;
  logic [1:0]            count_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [OUTPUT_WIDTH-1:0] fifo_data_q [2][2];  // [entry][lane]
  logic [1:0]            fifo_sop_q, fifo_eop_q;

  logic                  din_acc, pop, credit, rd_issue, head_eop;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DW-1:0]         rd_data;
  logic [HW-1:0]         h_re, h_im, h_in;
  int                    k_raw;
  logic [INPUT_WIDTH-1:0]  rd_lane [2];
  logic [OUTPUT_WIDTH-1:0] sc_lane [2];

  assign din_ready = din_ready_q;
  assign din_acc   = din_valid & din_ready_q;
  assign h_re      = lsb_count(din_real);
  assign h_im      = lsb_count(din_imag);
  assign h_in      = (h_re < h_im) ? h_re : h_im;
  assign k_raw     = (INPUT_WIDTH - OUTPUT_WIDTH) - int'(h_q);

  assign dout_valid = (count_q != 2'd0);
  assign pop        = dout_valid & dout_ready;
  assign head_eop   = fifo_eop_q[rd_ptr_q];

  // Keep at most two samples in flight or queued so the skid buffer never overflows.
  assign credit   = ({1'b0, count_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign rd_issue = (state_q == ST_CALC) |
                    ((state_q == ST_EMIT) & (rd_cnt_q < len_q) & credit);
  assign rd_addr  = rd_cnt_q[ADDR_WIDTH-1:0];

  // Frame control: collection, headroom tracking, shift computation, emit exit.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    h_d     = h_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    if (din_acc && din_sop) begin
      // A sop always starts a fresh frame, discarding any partial one.
      wr_en   = 1'b1;
      len_d   = LW'(1);
      h_d     = h_in;
      err_d   = din_error;
      ovf_d   = 1'b0;
      state_d = din_eop ? ST_CALC : ST_COLLECT;
    end else if (din_acc && (state_q == ST_COLLECT)) begin
      err_d = err_q | din_error;
      if (len_q < LW'(DEPTH)) begin
        wr_en   = 1'b1;
        wr_addr = len_q[ADDR_WIDTH-1:0];
        len_d   = len_q + LW'(1);
        h_d     = (h_in < h_q) ? h_in : h_q;
      end else begin
        ovf_d = 1'b1;
      end
      if (din_eop) state_d = ST_CALC;
    end else if (state_q == ST_CALC) begin
      k_d     = 6'(clamp_shift(k_raw));
      state_d = ST_EMIT;
    end else if ((state_q == ST_EMIT) && pop && head_eop) begin
      state_d = ST_IDLE;
    end
  end

  // Read address walks 0..len-1; the first read goes out during CALC so
  // sample 0 is ready the moment EMIT starts.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if ((state_q == ST_IDLE) || (state_q == ST_COLLECT)) rd_cnt_d = '0;
    else if (rd_issue) rd_cnt_d = rd_cnt_q + LW'(1);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      din_ready_q <= 1'b0;
      len_q       <= '0;
      h_q         <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      din_ready_q <= (state_d == ST_IDLE) || (state_d == ST_COLLECT);
      len_q       <= len_d;
      h_q         <= h_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      k_q         <= k_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  // RAM read-in-flight tracking and skid-buffer pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_sop_q <= '0;
      fifo_eop_q <= '0;
    end else begin
      infl_q     <= rd_issue;
      infl_sop_q <= (rd_cnt_q == '0);
      infl_eop_q <= (rd_cnt_q == (len_q - LW'(1)));
      count_q    <= count_q + {1'b0, infl_q} - {1'b0, pop};
      if (infl_q) begin
        wr_ptr_q             <= ~wr_ptr_q;
        fifo_sop_q[wr_ptr_q] <= infl_sop_q;
        fifo_eop_q[wr_ptr_q] <= infl_eop_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign rd_lane[gi] = rd_data[DW-1-gi*INPUT_WIDTH -: INPUT_WIDTH];
      assign sc_lane[gi] = scale(rd_lane[gi], k_q);
    end
  endgenerate

  // Skid-buffer payload, captured as each RAM read lands.
  always_ff @(posedge clk) begin
    if (infl_q) begin
      for (int l = 0; l < 2; l++) fifo_data_q[wr_ptr_q][l] <= sc_lane[l];
    end
  end

  assign dout_sop   = dout_valid & fifo_sop_q[rd_ptr_q];
  assign dout_eop   = dout_valid & fifo_eop_q[rd_ptr_q];
  assign dout_real  = dout_valid ? fifo_data_q[rd_ptr_q][0] : '0;
  assign dout_imag  = dout_valid ? fifo_data_q[rd_ptr_q][1] : '0;
  assign dout_exp   = dout_valid ? 6'(-k_q) : '0;
  assign dout_error = dout_valid ? (err_q | {ovf_q, 1'b0}) : '0;

  util_bfp_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i ({din_real, din_imag}),
    .rd_en_i   (rd_issue),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_util_bfp_normalizer.sv
// Directed and randomized frames against an arithmetic reference model.
module tb_util_bfp_normalizer;

  localparam int IW    = 24;
  localparam int OW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din_valid, din_ready, din_sop, din_eop;
  logic [IW-1:0] din_real, din_imag;
  logic [1:0]    din_error;
  logic          dout_ready, dout_valid, dout_sop, dout_eop;
  logic [OW-1:0] dout_real, dout_imag;
  logic [5:0]    dout_exp;
  logic [1:0]    dout_error;

  always #5 clk = ~clk;

  util_bfp_normalizer #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_sop(din_sop), .din_eop(din_eop),
    .din_real(din_real), .din_imag(din_imag), .din_error(din_error),
    .dout_ready(dout_ready), .dout_valid(dout_valid),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_real(dout_real), .dout_imag(dout_imag),
    .dout_exp(dout_exp), .dout_error(dout_error)
  );

  int total = 0;
  int bad   = 0;
  int frame_no = 0;

  longint     in_re[$];
  longint     in_im[$];
  logic [1:0] in_err[$];
  logic [41:0] exp_q[$];  // {sop, eop, real, imag, exp, error}
  logic [41:0] got_q[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Largest s such that v is representable as a (IW-s)-bit signed number.
  function automatic int headroom(input longint v);
    longint lim;
    for (int s = IW - 1; s >= 0; s--) begin
      lim = 1;
      repeat (IW - 1 - s) lim = lim * 2;
      if (v >= -lim && v < lim) return s;
    end
    return 0;
  endfunction

  // v * 2^-k with floor rounding, reduced to OW bits.
  function automatic logic [OW-1:0] mant(input longint v, input int k);
    longint d, q;
    d = 1;
    if (k > 0) begin
      repeat (k) d = d * 2;
      q = v / d;
      if (v < 0 && q * d != v) q = q - 1;
    end else begin
      repeat (-k) d = d * 2;
      q = v * d;
    end
    return q[OW-1:0];
  endfunction

  function automatic void build_expected();
    int n, stored, h, k;
    logic [1:0] err;
    exp_q.delete();
    n      = in_re.size();
    stored = (n > DEPTH) ? DEPTH : n;
    h      = IW - 1;
    err    = 2'b00;
    for (int i = 0; i < n; i++) err = err | in_err[i];
    if (n > DEPTH) err = err | 2'b10;
    for (int i = 0; i < stored; i++) begin
      if (headroom(in_re[i]) < h) h = headroom(in_re[i]);
      if (headroom(in_im[i]) < h) h = headroom(in_im[i]);
    end
    k = (IW - OW) - h;
    if (k < -4) k = -4;
    if (k > 21) k = 21;
    for (int i = 0; i < stored; i++)
      exp_q.push_back({(i == 0), (i == stored - 1), mant(in_re[i], k), mant(in_im[i], k),
                       6'(-k), err});
  endfunction

  function automatic void clear_frame();
    in_re.delete();
    in_im.delete();
    in_err.delete();
  endfunction

  function automatic void add_sample(input longint re, input longint im, input logic [1:0] e);
    in_re.push_back(re);
    in_im.push_back(im);
    in_err.push_back(e);
  endfunction

  function automatic longint rand_val();
    logic signed [IW-1:0] t;
    longint v, d;
    t = IW'($urandom);
    v = longint'(t);
    d = 1;
    repeat ($urandom_range(0, IW - 1)) d = d * 2;
    return v / d;
  endfunction

  // Drive the queued samples back to back; the sop is on the first one.
  task automatic send_frame(input bit with_eop);
    int n, guard;
    n = in_re.size();
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din_sop   = (i == 0);
      din_eop   = with_eop && (i == n - 1);
      din_real  = in_re[i][IW-1:0];
      din_imag  = in_im[i][IW-1:0];
      din_error = in_err[i];
      guard = 0;
      while (!din_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) check("din_ready_timeout", 64'(din_ready), 64'd1);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
    din_error = 2'b00;
  endtask

  // Entered one cycle after the eop transfer; collects and checks one frame.
  task automatic collect_frame(input bit random_ready);
    int lat, idx, guard;
    bit r, held;
    logic [41:0] cur, held_word;
    got_q.delete();
    frame_no++;
    check("din_ready_low_after_eop", 64'(din_ready), 64'd0);
    lat = 1;
    while (!dout_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_latency", 64'(lat), 64'd3);
    idx = 0; guard = 0; held = 1'b0; held_word = '0;
    while (idx < exp_q.size() && guard < 3000) begin
      r = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      dout_ready = r;
      cur = {dout_sop, dout_eop, dout_real, dout_imag, dout_exp, dout_error};
      if (held) check("stall_hold_stable", {21'd0, dout_valid, cur}, {21'd0, 1'b1, held_word});
      held = 1'b0;
      if (dout_valid) begin
        if (r) begin
          check($sformatf("beat f%0d i%0d", frame_no, idx), 64'(cur), 64'(exp_q[idx]));
          $display("frame %0d beat %0d sop=%0b eop=%0b re=%h im=%h exp=%0d err=%b",
                   frame_no, idx, dout_sop, dout_eop, dout_real, dout_imag,
                   $signed(dout_exp), dout_error);
          got_q.push_back(cur);
          idx++;
        end else begin
          held = 1'b1;
          held_word = cur;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) check("output_timeout", 64'(idx), 64'(exp_q.size()));
    dout_ready = 1'b1;
    check("idle_after_frame", {62'd0, din_ready, dout_valid}, 64'b10);
  endtask

  initial begin
    longint v, m, e;
    int guard;
    rst_n = 1'b0; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    din_real = '0; din_imag = '0; din_error = 2'b00; dout_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({din_ready, dout_valid, dout_sop, dout_eop, dout_real, dout_imag, dout_exp, dout_error}),
          64'd0);
    rst_n = 1'b1;
    check("din_ready_before_first_edge", 64'(din_ready), 64'd0);
    @(posedge clk); #1;
    check("din_ready_after_release", 64'(din_ready), 64'd1);

    // Small peak: left shift by 3.
    clear_frame();
    add_sample(64'sh000FFF, 0, 2'b00);
    add_sample(64'sh000100, 0, 2'b00);
    add_sample(-5, 0, 2'b00);
    add_sample(0, 0, 2'b00);
    build_expected();
    send_frame(1'b1);
    collect_frame(1'b0);
    check("t1_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      check("t1_peak_mant", 64'(got_q[0][39:24]), 64'h7FF8);
      check("t1_exp", 64'(got_q[0][7:2]), 64'd3);
    end

    // Full-scale extremes: right shift by 8.
    clear_frame();
    add_sample(64'sh7FFFFF, 0, 2'b00);
    add_sample(-64'sh800000, 0, 2'b00);
    build_expected();
    send_frame(1'b1);
    collect_frame(1'b0);
    check("t2_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t2_max_mant", 64'(got_q[0][39:24]), 64'h7FFF);
      check("t2_min_mant", 64'(got_q[1][39:24]), 64'h8000);
      check("t2_exp", 64'(got_q[1][7:2]), 64'h38);
    end

    // All-zero frame: shift clamps at -4.
    clear_frame();
    add_sample(0, 0, 2'b00);
    add_sample(0, 0, 2'b00);
    build_expected();
    send_frame(1'b1);
    collect_frame(1'b0);
    check("t3_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t3_exp", 64'(got_q[0][7:2]), 64'd4);
      check("t3_mant", 64'(got_q[1][39:8]), 64'd0);
    end

    // Oversized frame: 20 in, 16 out, overflow flagged.
    clear_frame();
    for (int i = 0; i < 20; i++)
      if (i < 16) add_sample(rand_val(), rand_val(), 2'b00);
      else        add_sample(0, 0, 2'b00);
    build_expected();
    send_frame(1'b1);
    collect_frame(1'b0);
    check("t4_count", 64'(got_q.size()), 64'd16);
    if (got_q.size() == 16) begin
      check("t4_last_eop", 64'(got_q[15][40]), 64'd1);
      check("t4_error", 64'(got_q[15][1:0]), 64'b10);
    end

    // Backpressure; reconstruct through the scaler relation value = mant * 2^-exp.
    clear_frame();
    for (int i = 0; i < 16; i++)
      add_sample(longint'($urandom_range(0, 32767)) - 16384,
                 longint'($urandom_range(0, 32767)) - 16384, 2'b00);
    build_expected();
    send_frame(1'b1);
    collect_frame(1'b1);
    check("t5_count", 64'(got_q.size()), 64'd16);
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      m = longint'($signed(got_q[i][39:24]));
      e = longint'($signed(got_q[i][7:2]));
      v = m;
      for (longint j = 0; j < e; j++) v = v / 2;
      for (longint j = e; j < 0; j++) v = v * 2;
      check($sformatf("t5_recon_%0d", i), 64'(v), 64'(in_re[i]));
    end

    // Stray non-sop samples in IDLE, then an aborted partial frame, then a real one.
    din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'b1;
    din_real = 24'h123456; din_imag = 24'h654321; din_error = 2'b11;
    @(posedge clk); #1;
    din_valid = 1'b0; din_eop = 1'b0;
    check("idle_drop_no_output", 64'({dout_valid, din_ready}), 64'b01);
    clear_frame();
    for (int i = 0; i < 3; i++) add_sample(64'sh7FFFFF, -64'sh800000, 2'b01);
    send_frame(1'b0);
    clear_frame();
    add_sample(300, -7, 2'b00);
    add_sample(-1024, 12, 2'b00);
    build_expected();
    send_frame(1'b1);
    collect_frame(1'b1);
    check("t6_count", 64'(got_q.size()), 64'd2);

    // Reset while the frame is being emitted.
    clear_frame();
    for (int i = 0; i < 8; i++) add_sample(rand_val(), rand_val(), 2'b00);
    send_frame(1'b1);
    dout_ready = 1'b0;
    guard = 0;
    while (!dout_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t7_valid_seen", 64'(dout_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t7_reset_mid_emit", 64'({din_ready, dout_valid, dout_sop, dout_eop, dout_real}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t7_ready_after_release", 64'({din_ready, dout_valid}), 64'b10);
    dout_ready = 1'b1;

    // Random frames, full-range values, error flags, backpressure.
    for (int f = 0; f < 10; f++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      clear_frame();
      for (int i = 0; i < n; i++)
        add_sample(rand_val(), rand_val(),
                   ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
      build_expected();
      send_frame(1'b1);
      collect_frame(f[0]);
      check($sformatf("rand_count_%0d", f), 64'(got_q.size()), 64'(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
